conv_weight_streamer: RTL and testbench
=======================================

CONV_WEIGHT_STREAMER -- requirements
Module: conv_weight_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, weight word width.
REQ-002 SHALL have parameter KERNEL, default 7, kernel width and height.
REQ-003 SHALL have parameter CHANNEL_NUM_IN, default 3, input channels per output channel.
REQ-004 SHALL have parameter CHANNEL_NUM_OUT, default 64, number of output channels (groups).
REQ-005 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between groups.
REQ-006 SHALL have parameter ADDR_WIDTH, default 14, weight-RAM address width, covering TOTAL = KERNEL*KERNEL*CHANNEL_NUM_IN*CHANNEL_NUM_OUT words.
REQ-007 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port wr_en  input  1  weight-RAM load strobe.
REQ-010 SHALL have port wr_addr  input  ADDR_WIDTH  load address.
REQ-011 SHALL have port wr_data  input  DATA_WIDTH  load data.
REQ-012 SHALL have port start  input  1  one-cycle request to stream all weights.
REQ-013 SHALL have port stall  input  1  consumer back-pressure.
REQ-014 SHALL have port abort  input  1  terminate streaming.
REQ-015 SHALL have port weight_out  output  DATA_WIDTH  weight word, drives conv valid_weight_in/weight_in.
REQ-016 SHALL have port valid_weight_out  output  1  weight_out valid this cycle.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse with last weight of a pass.

Function
REQ-019 SHALL hold an internal TOTAL-deep synchronous-read RAM; read latency exactly 1 cycle.
REQ-020 SHALL accept wr_en writes only in IDLE; writes while busy SHALL be dropped.
REQ-021 SHALL implement states IDLE, SEND, GAP, FLUSH.
REQ-022 IDLE->SEND on start; read address cleared to 0; start while busy ignored.
REQ-023 In SEND with stall low: issue read at current address, increment address; with stall high: no read, address held.
REQ-024 valid_weight_out SHALL equal the read-issued flag delayed 1 cycle; weight_out = RAM data of that read; weight_out holds last value when valid low.
REQ-025 Stall has 1-cycle skid: a read issued in the cycle before stall rises still emerges valid; consumer SHALL absorb it.
REQ-026 After issuing the last address of a group (KERNEL*KERNEL*CHANNEL_NUM_IN reads) and GAP_CYCLES>0 and not the final group: SEND->GAP for exactly GAP_CYCLES cycles, then SEND; GAP_CYCLES=0 skips GAP.
REQ-027 After issuing address TOTAL-1: SEND->FLUSH; next cycle done pulses together with last valid_weight_out, then FLUSH->IDLE.
REQ-028 abort high in SEND/GAP/FLUSH: next state IDLE, in-flight read's valid squashed, done not pulsed; abort wins over start and stall.
REQ-029 Exactly TOTAL valid words per completed pass, in address order 0..TOTAL-1, no duplicates.

Reset
REQ-030 On reset: state IDLE, address 0, valid_weight_out 0, weight_out 0, done 0, busy 0, gap counter 0.
REQ-031 Reset mid-stream SHALL abandon the pass with no valid or done after reset; RAM contents SHALL NOT be cleared.

Configuration
REQ-032 Macro CONV_WEIGHT_STREAMER_LOOP_EN: when defined, FLUSH is skipped; after address TOTAL-1, done pulses with last word, GAP_CYCLES gap is applied, streaming restarts at address 0; only abort or reset return to IDLE.
REQ-033 Without CONV_WEIGHT_STREAMER_LOOP_EN, single pass per start per REQ-027.

Verification (KERNEL=3, CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2, TOTAL=36)
REQ-034 Load RAM[i]=i+100, start, stall 0, GAP_CYCLES=0 -> 36 consecutive valid words 100..135 starting 2 cycles after start, done with 135, busy low next cycle.
REQ-035 GAP_CYCLES=4 -> valid words 100..117, exactly 4 invalid cycles, then 118..135; one gap only.
REQ-036 stall high for 3 cycles after word 110 issue -> 111 still emerges once (skid), 3-cycle hole, resume 112, total count 36, no duplicates.
REQ-037 abort at word 120 -> busy low next cycle, no further valid, no done; subsequent start streams 100..135 from 0.
REQ-038 wr_en to addr 5 with data 999 while busy -> stream unchanged (105); after done, write succeeds, next pass emits 999 at position 5.
REQ-039 With CONV_WEIGHT_STREAMER_LOOP_EN: two full passes emit 100..135 twice, done pulses twice, abort stops within 1 cycle.

Source files
------------

// File: rtl/conv_weight_streamer.sv
// conv_weight_streamer: weight RAM plus a read sequencer that streams every
// stored weight, group by group, into a convolution engine.
// Optional build macro CONV_WEIGHT_STREAMER_LOOP_EN: stream continuously,
// restarting at address 0 after each pass until abort or reset.
module conv_weight_streamer #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned KERNEL          = 7,
   parameter int unsigned CHANNEL_NUM_IN  = 3,
   parameter int unsigned CHANNEL_NUM_OUT = 64,
   parameter int unsigned GAP_CYCLES      = 0,
   parameter int unsigned ADDR_WIDTH      = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  start,
   input  logic                  stall,
   input  logic                  abort,
   output logic [DATA_WIDTH-1:0] weight_out,
   output logic                  valid_weight_out,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned GROUP = KERNEL * KERNEL * CHANNEL_NUM_IN;
   localparam int unsigned TOTAL = GROUP * CHANNEL_NUM_OUT;
   localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int unsigned GRP_W = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef CONV_WEIGHT_STREAMER_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SEND, GAP, FLUSH} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] mem [TOTAL];
   logic [ADDR_WIDTH-1:0] addr;
   logic [GRP_W-1:0]      grp_cnt;
   logic [GAP_W-1:0]      gap_cnt;
   logic                  issue_c;
   logic                  last_total_c;
   logic                  grp_end_c;
   logic                  gap_end_c;
   logic                  valid_nxt;
   logic                  done_nxt;
   logic                  busy_nxt;

   // A read is issued only while sending, not back-pressured and not aborting.
   assign issue_c      = (state == SEND) && !stall && !abort;
   assign last_total_c = (addr == ADDR_WIDTH'(TOTAL - 1));
   assign grp_end_c    = (grp_cnt == GRP_W'(GROUP - 1));
   assign gap_end_c    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; abort takes priority over everything else.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start && !abort) state_nxt = SEND;
         end
         SEND: begin
            if (abort)
               state_nxt = IDLE;
            else if (issue_c && last_total_c)
               state_nxt = LOOP_EN ? ((GAP_CYCLES > 0) ? GAP : SEND) : FLUSH;
            else if (issue_c && grp_end_c && (GAP_CYCLES > 0))
               state_nxt = GAP;
         end
         GAP: begin
            if (abort)          state_nxt = IDLE;
            else if (gap_end_c) state_nxt = SEND;
         end
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: valid/done follow the read issue by one cycle.
   always_comb begin
      valid_nxt = issue_c;
      done_nxt  = issue_c && last_total_c;
      busy_nxt  = (state_nxt != IDLE);
   end

   // Weight RAM load port; only open while idle, contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && (state == IDLE) && (32'(wr_addr) < TOTAL))
         mem[IDX_W'(wr_addr)] <= wr_data;
   end

   // Read data register, address/group/gap counters and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr             <= '0;
         grp_cnt          <= '0;
         gap_cnt          <= '0;
         weight_out       <= '0;
         valid_weight_out <= 1'b0;
         done             <= 1'b0;
         busy             <= 1'b0;
      end else begin
         valid_weight_out <= valid_nxt;
         done             <= done_nxt;
         busy             <= busy_nxt;
         if (issue_c)
            weight_out <= mem[IDX_W'(addr)];
         if (state == IDLE) begin
            addr    <= '0;
            grp_cnt <= '0;
         end else if (issue_c) begin
            addr    <= last_total_c ? '0 : addr + ADDR_WIDTH'(1);
            grp_cnt <= grp_end_c ? '0 : grp_cnt + GRP_W'(1);
         end
         gap_cnt <= ((state == GAP) && (state_nxt == GAP)) ? gap_cnt + GAP_W'(1) : '0;
      end
   end

endmodule

// File: tb/tb_conv_weight_streamer.sv
// tb_conv_weight_streamer: two instances (no gap / 4-cycle gap) sharing
// stimulus, checked against a transaction-level model and directed tables.
module tb_conv_weight_streamer;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;
   localparam int unsigned GROUP = 18;
   localparam int unsigned TOTAL = 36;
`ifdef CONV_WEIGHT_STREAMER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          start;
   logic          stall;
   logic          abort;
   logic [DW-1:0] wo0, wo4;
   logic          v0, v4, b0, b4, d0, d4;

   conv_weight_streamer #(.DATA_WIDTH(DW), .KERNEL(3), .CHANNEL_NUM_IN(2),
      .CHANNEL_NUM_OUT(2), .GAP_CYCLES(0), .ADDR_WIDTH(AW)) dut0 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stall(stall), .abort(abort), .weight_out(wo0),
      .valid_weight_out(v0), .busy(b0), .done(d0));

   conv_weight_streamer #(.DATA_WIDTH(DW), .KERNEL(3), .CHANNEL_NUM_IN(2),
      .CHANNEL_NUM_OUT(2), .GAP_CYCLES(4), .ADDR_WIDTH(AW)) dut4 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stall(stall), .abort(abort), .weight_out(wo4),
      .valid_weight_out(v4), .busy(b4), .done(d4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state, index 0 = no gap, 1 = 4-cycle gap.
   logic [DW-1:0] m_mem [2][TOTAL];
   bit            m_busy [2];
   bit            m_flush [2];
   int            m_pos [2];
   int            m_gap [2];
   bit            e_valid [2];
   bit            e_done [2];
   logic [DW-1:0] e_word [2];

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (gap%0d) t=%0t: got %0d, expected %0d", name, (d == 0) ? 0 : 4, $time, act, exp);
      end
   endtask

   // One cycle of the streamer described as a sequence of word positions.
   task automatic model_step(input int d, input bit s, input bit st, input bit ab,
                             input bit we, input int wa, input logic [DW-1:0] wd);
      int gap;
      gap = (d == 0) ? 0 : 4;
      e_valid[d] = 1'b0;
      e_done[d]  = 1'b0;
      if (!m_busy[d]) begin
         if (we && (wa < TOTAL)) m_mem[d][wa] = wd;
         if (s && !ab) begin
            m_busy[d]  = 1'b1;
            m_pos[d]   = 0;
            m_gap[d]   = 0;
            m_flush[d] = 1'b0;
         end
      end else if (ab || m_flush[d]) begin
         m_busy[d] = 1'b0;
      end else if (m_gap[d] > 0) begin
         m_gap[d]--;
      end else if (!st) begin
         e_valid[d] = 1'b1;
         e_word[d]  = m_mem[d][m_pos[d]];
         if (m_pos[d] == TOTAL - 1) begin
            e_done[d] = 1'b1;
            if (LOOP) begin
               m_pos[d] = 0;
               m_gap[d] = gap;
            end else begin
               m_flush[d] = 1'b1;
            end
         end else begin
            m_pos[d]++;
            if (m_pos[d] % GROUP == 0) m_gap[d] = gap;
         end
      end
   endtask

   task automatic cycle(input bit s, input bit st, input bit ab, input bit we,
                        input int wa, input logic [DW-1:0] wd);
      start   = s;
      stall   = st;
      abort   = ab;
      wr_en   = we;
      wr_addr = AW'(wa);
      wr_data = wd;
      for (int d = 0; d < 2; d++) model_step(d, s, st, ab, we, wa, wd);
      @(posedge clk);
      #1;
      check("model valid", 0, 32'(v0), 32'(e_valid[0]));
      check("model word",  0, wo0,     e_word[0]);
      check("model done",  0, 32'(d0), 32'(e_done[0]));
      check("model busy",  0, 32'(b0), 32'(m_busy[0]));
      check("model valid", 1, 32'(v4), 32'(e_valid[1]));
      check("model word",  1, wo4,     e_word[1]);
      check("model done",  1, 32'(d4), 32'(e_done[1]));
      check("model busy",  1, 32'(b4), 32'(m_busy[1]));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      abort = 1'b0;
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_busy[d]  = 1'b0;
         m_flush[d] = 1'b0;
         m_pos[d]   = 0;
         m_gap[d]   = 0;
         e_word[d]  = '0;
      end
      check("reset valid",  0, 32'(v0), 32'd0);
      check("reset done",   0, 32'(d0), 32'd0);
      check("reset busy",   0, 32'(b0), 32'd0);
      check("reset weight", 0, wo0,     32'd0);
      check("reset valid",  1, 32'(v4), 32'd0);
      check("reset done",   1, 32'(d4), 32'd0);
      check("reset busy",   1, 32'(b4), 32'd0);
      check("reset weight", 1, wo4,     32'd0);
   endtask

`ifdef CONV_WEIGHT_STREAMER_LOOP_EN
   // Two back-to-back passes without a gap, then abort.
   task automatic loop_seq();
      int  dones;
      bit  ev;
      int  p;
      dones = 0;
      for (int k = 1; k <= 77; k++) begin
         cycle(k == 1, 1'b0, k == 74, 1'b0, 0, '0);
         ev = (k >= 2) && (k <= 73);
         p  = (k - 2) % 36;
         check("loop valid", 0, 32'(v0), 32'(ev));
         if (ev) check("loop word", 0, wo0, 32'(100 + p));
         check("loop done", 0, 32'(d0), 32'((k == 37) || (k == 73)));
         check("loop busy", 0, 32'(b0), 32'(k <= 73));
         if (d0) dones++;
      end
      check("loop done count", 0, 32'(dones), 32'd2);
   endtask
`else
   // Single pass, stall low; optional write attempt while busy at call wr_k.
   task automatic full_pass_check(input int wr_k, input logic [DW-1:0] v5);
      bit ev0, ev4;
      int p0, p4;
      for (int k = 1; k <= 45; k++) begin
         cycle(k == 1, 1'b0, 1'b0, k == wr_k, 5, 32'd999);
         ev0 = (k >= 2) && (k <= 37);
         p0  = k - 2;
         ev4 = ((k >= 2) && (k <= 19)) || ((k >= 24) && (k <= 41));
         p4  = (k <= 19) ? k - 2 : k - 6;
         check("pass valid", 0, 32'(v0), 32'(ev0));
         if (ev0) check("pass word", 0, wo0, (p0 == 5) ? v5 : 32'(100 + p0));
         check("pass done", 0, 32'(d0), 32'(k == 37));
         check("pass busy", 0, 32'(b0), 32'(k <= 37));
         check("pass valid", 1, 32'(v4), 32'(ev4));
         if (ev4) check("pass word", 1, wo4, (p4 == 5) ? v5 : 32'(100 + p4));
         check("pass done", 1, 32'(d4), 32'(k == 41));
         check("pass busy", 1, 32'(b4), 32'(k <= 41));
      end
   endtask

   // Stall for three cycles while 111 is already in flight.
   task automatic stall_seq();
      logic [DW-1:0] got [$];
      bit ev;
      int p;
      int bad;
      for (int k = 1; k <= 45; k++) begin
         cycle(k == 1, (k >= 14) && (k <= 16), 1'b0, 1'b0, 0, '0);
         ev = ((k >= 2) && (k <= 13)) || ((k >= 17) && (k <= 40));
         p  = (k <= 13) ? k - 2 : k - 5;
         check("stall valid", 0, 32'(v0), 32'(ev));
         if (ev) check("stall word", 0, wo0, 32'(100 + p));
         check("stall done", 0, 32'(d0), 32'(k == 40));
         if (v0) got.push_back(wo0);
      end
      check("stall count", 0, 32'(got.size()), 32'd36);
      bad = 0;
      foreach (got[i]) if (got[i] != 32'(100 + i)) bad++;
      check("stall order", 0, 32'(bad), 32'd0);
   endtask

   // Abort while word 120 is on the output, then a clean restart.
   task automatic abort_seq();
      for (int k = 1; k <= 28; k++) begin
         cycle(k == 1, 1'b0, k == 23, 1'b0, 0, '0);
         if (k == 22) begin
            check("abort pre valid", 0, 32'(v0), 32'd1);
            check("abort pre word",  0, wo0,     32'd120);
         end
         if (k >= 23) begin
            check("abort valid", 0, 32'(v0), 32'd0);
            check("abort busy",  0, 32'(b0), 32'd0);
            check("abort done",  0, 32'(d0), 32'd0);
         end
      end
      full_pass_check(0, 32'd105);
   endtask
`endif

   typedef struct {
      bit            start;
      bit            stall;
      bit            abort;
      bit            valid;
      bit            done;
      bit            busy;
      logic [DW-1:0] word;
   } vec_t;

   initial begin
      vec_t tbl [11];
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd100};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd101};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd102};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd103};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

      reset   = 1'b1;
      start   = 1'b0;
      stall   = 1'b0;
      abort   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      repeat (2) @(posedge clk);
      do_reset();

      for (int i = 0; i < 36; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, i, 32'(i + 100));

      foreach (tbl[i]) begin
         cycle(tbl[i].start, tbl[i].stall, tbl[i].abort, 1'b0, 0, '0);
         check("tbl valid", 0, 32'(v0), 32'(tbl[i].valid));
         check("tbl done",  0, 32'(d0), 32'(tbl[i].done));
         check("tbl busy",  0, 32'(b0), 32'(tbl[i].busy));
         if (tbl[i].valid) check("tbl word", 0, wo0, tbl[i].word);
         check("tbl valid", 1, 32'(v4), 32'(tbl[i].valid));
         check("tbl busy",  1, 32'(b4), 32'(tbl[i].busy));
         if (tbl[i].valid) check("tbl word", 1, wo4, tbl[i].word);
      end

      // Reset in the middle of a pass: nothing emerges afterwards.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
      repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
         check("post reset valid", 0, 32'(v0), 32'd0);
         check("post reset done",  0, 32'(d0), 32'd0);
         check("post reset valid", 1, 32'(v4), 32'd0);
      end

`ifdef CONV_WEIGHT_STREAMER_LOOP_EN
      loop_seq();
`else
      full_pass_check(0, 32'd105);
      full_pass_check(3, 32'd105);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 5, 32'd999);
      full_pass_check(0, 32'd999);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 5, 32'd105);
      stall_seq();
      abort_seq();
`endif

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0)
            do_reset();
         else
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 63)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
